// File: rtl/enc_quad_counter.sv
// Quadrature encoder position counter with a small CPU register slot.
// x4 decode, signed limits with optional wrap, sticky events and a level irq.
module enc_quad_counter #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        btn,
    input  logic        sw,
    output logic        irq
);

    localparam logic [CNT_W-1:0] One    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MinRst = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] MaxRst = {1'b0, {(CNT_W-1){1'b1}}};

    // Synchronizer lanes: {sw, btn, a, b}
    logic [3:0] sync1_q, sync2_q;
    logic [1:0] prev_ab_q;
    logic       btn_prev_q;

    logic signed [CNT_W-1:0] pos_q, pos_d;
    logic signed [CNT_W-1:0] lim_min_q, lim_min_d;
    logic signed [CNT_W-1:0] lim_max_q, lim_max_d;
    logic        dir_q, dir_d;
    logic        step_st_q, step_st_d;
    logic        btn_st_q, btn_st_d;
    logic        err_st_q, err_st_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [5:0]  ctrl_q, ctrl_d;

    logic [1:0] ab;
    logic       btn_s, sw_s, btn_rise;
    logic       inc, dec, jump, step_evt, err_evt, frozen;
    logic       we, wr_pos, wr_ctrl, wr_min, wr_max, wr_clr;
    logic       unused_sigs;

    assign ab       = sync2_q[1:0];
    assign btn_s    = sync2_q[2];
    assign sw_s     = sync2_q[3];
    assign btn_rise = btn_s & ~btn_prev_q;

    assign inc = ({prev_ab_q, ab} == 4'b0001) || ({prev_ab_q, ab} == 4'b0111) ||
                 ({prev_ab_q, ab} == 4'b1110) || ({prev_ab_q, ab} == 4'b1000);
    assign dec = ({prev_ab_q, ab} == 4'b0100) || ({prev_ab_q, ab} == 4'b1101) ||
                 ({prev_ab_q, ab} == 4'b1011) || ({prev_ab_q, ab} == 4'b0010);
    assign jump     = (prev_ab_q ^ ab) == 2'b11;
    assign step_evt = ctrl_q[0] & (inc | dec);
    assign err_evt  = ctrl_q[0] & jump;
    assign frozen   = lim_min_q > lim_max_q;

    assign we      = cs & write;
    assign wr_pos  = we & (addr == 5'd0);
    assign wr_ctrl = we & (addr == 5'd2);
    assign wr_min  = we & (addr == 5'd3);
    assign wr_max  = we & (addr == 5'd4);
    assign wr_clr  = we & (addr == 5'd5);

    assign unused_sigs = ^{read, wr_data[31:CNT_W]};

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_evt) begin
            dir_d = inc;
            if (!frozen) begin
                if (inc) begin
                    if (pos_q >= lim_max_q) pos_d = ctrl_q[1] ? lim_min_q : pos_q;
                    else                    pos_d = pos_q + One;
                end else begin
                    if (pos_q <= lim_min_q) pos_d = ctrl_q[1] ? lim_max_q : pos_q;
                    else                    pos_d = pos_q - One;
                end
            end
        end
        if (ctrl_q[5] && btn_rise) pos_d = '0;
        if (wr_pos)                pos_d = wr_data[CNT_W-1:0];
    end

    always_comb begin
        // A same-cycle event overrides a clear of its own sticky bit.
        step_st_d = (step_st_q & ~(wr_clr & wr_data[0])) | step_evt;
        btn_st_d  = (btn_st_q  & ~(wr_clr & wr_data[1])) | btn_rise;
        err_st_d  = (err_st_q  & ~(wr_clr & wr_data[2])) | err_evt;
        err_cnt_d = (wr_clr && wr_data[2]) ? 8'd0 : err_cnt_q;
        if (err_evt && (err_cnt_d != 8'hFF)) err_cnt_d = err_cnt_d + 8'd1;
        ctrl_d    = wr_ctrl ? wr_data[5:0]       : ctrl_q;
        lim_min_d = wr_min  ? wr_data[CNT_W-1:0] : lim_min_q;
        lim_max_d = wr_max  ? wr_data[CNT_W-1:0] : lim_max_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_ab_q  <= '0;
            btn_prev_q <= 1'b0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            step_st_q  <= 1'b0;
            btn_st_q   <= 1'b0;
            err_st_q   <= 1'b0;
            err_cnt_q  <= '0;
            ctrl_q     <= 6'h01;
            lim_min_q  <= MinRst;
            lim_max_q  <= MaxRst;
        end else begin
            sync1_q    <= {sw, btn, enc_a, enc_b};
            sync2_q    <= sync1_q;
            prev_ab_q  <= ab;
            btn_prev_q <= btn_s;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_st_q  <= step_st_d;
            btn_st_q   <= btn_st_d;
            err_st_q   <= err_st_d;
            err_cnt_q  <= err_cnt_d;
            ctrl_q     <= ctrl_d;
            lim_min_q  <= lim_min_d;
            lim_max_q  <= lim_max_d;
        end
    end

    assign irq = (ctrl_q[2] & step_st_q) | (ctrl_q[3] & btn_st_q) | (ctrl_q[4] & err_st_q);

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: rd_data = {{(32-CNT_W){pos_q[CNT_W-1]}}, pos_q};
            5'd1: rd_data = {16'd0, err_cnt_q, 2'b00, err_st_q, btn_st_q, step_st_q,
                             btn_s, sw_s, dir_q};
            5'd2: rd_data = {26'd0, ctrl_q};
            5'd3: rd_data = {{(32-CNT_W){lim_min_q[CNT_W-1]}}, lim_min_q};
            5'd4: rd_data = {{(32-CNT_W){lim_max_q[CNT_W-1]}}, lim_max_q};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_enc_quad_counter.sv
// Self-checking bench for enc_quad_counter: expected register reads are queued
// as stimulus is applied and compared against rd_data when drained.
module tb_enc_quad_counter;

    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        enc_a = 1'b0, enc_b = 1'b0, btn = 1'b0, sw = 1'b0;
    logic        irq;

    enc_quad_counter #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .btn     (btn),
        .sw      (sw),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  a;
        logic [31:0] mask;
        logic [31:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] ab = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] mask,
                              input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.a = a; e.mask = mask; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            addr = e.a;
            #1;
            check_eq(e.tag, rd_data & e.mask, e.exp & e.mask);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    function automatic logic [1:0] next_ab(input logic [1:0] cur, input bit cw);
        case (cur)
            2'b00:   next_ab = cw ? 2'b01 : 2'b10;
            2'b01:   next_ab = cw ? 2'b11 : 2'b00;
            2'b11:   next_ab = cw ? 2'b10 : 2'b01;
            default: next_ab = cw ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic drive_ab(input logic [1:0] v);
        @(negedge clk);
        ab = v;
        {enc_a, enc_b} = v;
    endtask

    task automatic step(input bit cw);
        drive_ab(next_ab(ab, cw));
        wait_clks(3);
    endtask

    task automatic jump();
        drive_ab(ab ^ 2'b11);
        wait_clks(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(1);

        // Reset state
        expect_reg("rst_pos",    5'd0, '1, 32'h0000_0000);
        expect_reg("rst_status", 5'd1, '1, 32'h0000_0000);
        expect_reg("rst_ctrl",   5'd2, '1, 32'h0000_0001);
        expect_reg("rst_min",    5'd3, '1, 32'hFFFF_8000);
        expect_reg("rst_max",    5'd4, '1, 32'h0000_7FFF);
        expect_reg("rst_clear",  5'd5, '1, 32'h0000_0000);
        expect_reg("rst_unmap",  5'd9, '1, 32'h0000_0000);
        drain();
        check_eq("rst_irq", {31'd0, irq}, 32'd0);

        // Edge-to-POS latency: unchanged after 2 clk, updated after 3
        drive_ab(next_ab(ab, 1'b1));
        wait_clks(2);
        expect_reg("lat2", 5'd0, '1, 32'd0);
        drain();
        wait_clks(1);
        expect_reg("lat3", 5'd0, '1, 32'd1);
        drain();
        step(1'b0);

        // Four CW then four CCW cycles
        for (int i = 0; i < 16; i++) step(1'b1);
        expect_reg("cw_pos",    5'd0, '1, 32'd16);
        expect_reg("cw_status", 5'd1, '1, 32'h0000_0009);
        drain();
        for (int i = 0; i < 16; i++) step(1'b0);
        expect_reg("ccw_pos",    5'd0, '1, 32'd0);
        expect_reg("ccw_status", 5'd1, '1, 32'h0000_0008);
        drain();
        reg_wr(5'd5, 32'h1);
        expect_reg("clr_step", 5'd1, '1, 32'h0000_0000);
        reg_wr(5'd1, 32'hFFFF);
        expect_reg("ro_status", 5'd1, '1, 32'h0000_0000);
        drain();

        // Slide switch level
        sw = 1'b1;
        wait_clks(3);
        expect_reg("sw_level", 5'd1, 32'h2, 32'h2);
        drain();
        sw = 1'b0;
        wait_clks(3);

        // Disabled: no count, no sticky, but prev_ab tracks
        reg_wr(5'd2, 32'h0);
        step(1'b1);
        expect_reg("dis_pos",    5'd0, '1, 32'd0);
        expect_reg("dis_status", 5'd1, '1, 32'h0);
        drain();
        reg_wr(5'd2, 32'h1);
        step(1'b0);
        expect_reg("reen_pos", 5'd0, '1, 32'hFFFF_FFFF);
        drain();
        reg_wr(5'd0, 32'h0);

        // Limits: hold at MAX, then wrap both ways
        reg_wr(5'd4, 32'd5);
        for (int i = 0; i < 8; i++) step(1'b1);
        expect_reg("lim_hold", 5'd0, '1, 32'd5);
        drain();
        reg_wr(5'd2, 32'h3);
        reg_wr(5'd3, 32'hFFFF_FFFB);
        expect_reg("min_rd", 5'd3, '1, 32'hFFFF_FFFB);
        drain();
        step(1'b1);
        expect_reg("wrap_max", 5'd0, '1, 32'hFFFF_FFFB);
        drain();
        step(1'b0);
        expect_reg("wrap_min", 5'd0, '1, 32'd5);
        drain();

        // Inverted limits freeze the count but still flag the step
        reg_wr(5'd2, 32'h1);
        reg_wr(5'd3, 32'd10);
        reg_wr(5'd5, 32'h1);
        step(1'b1);
        expect_reg("frz_pos",  5'd0, '1, 32'd5);
        expect_reg("frz_step", 5'd1, 32'h8, 32'h8);
        drain();
        reg_wr(5'd3, 32'hFFFF_8000);
        reg_wr(5'd4, 32'h0000_7FFF);
        reg_wr(5'd0, 32'h0);

        // Double jumps
        jump();
        wait_clks(2);
        expect_reg("jmp_pos", 5'd0, '1, 32'd0);
        expect_reg("jmp_err", 5'd1, 32'hFF20, 32'h0120);
        drain();
        for (int i = 0; i < 299; i++) jump();
        wait_clks(2);
        expect_reg("jmp_sat", 5'd1, 32'hFF20, 32'hFF20);
        drain();
        reg_wr(5'd5, 32'h4);
        expect_reg("jmp_clr", 5'd1, 32'hFF20, 32'h0000);
        drain();

        // Button clear beats a same-cycle step
        reg_wr(5'd2, 32'h21);
        reg_wr(5'd0, 32'd7);
        @(negedge clk);
        btn = 1'b1;
        ab = next_ab(ab, 1'b1);
        {enc_a, enc_b} = ab;
        wait_clks(3);
        expect_reg("btn_clr",  5'd0, '1, 32'd0);
        expect_reg("btn_stky", 5'd1, 32'h14, 32'h14);
        drain();

        // CPU write beats button clear and step
        btn = 1'b0;
        wait_clks(4);
        reg_wr(5'd0, 32'd7);
        @(negedge clk);
        btn = 1'b1;
        ab = next_ab(ab, 1'b1);
        {enc_a, enc_b} = ab;
        wait_clks(2);
        cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = 32'd9;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        wait_clks(2);
        expect_reg("cpu_win", 5'd0, '1, 32'd9);
        drain();

        // Button interrupt
        btn = 1'b0;
        wait_clks(4);
        reg_wr(5'd2, 32'h09);
        reg_wr(5'd5, 32'h7);
        check_eq("irq_idle", {31'd0, irq}, 32'd0);
        @(negedge clk);
        btn = 1'b1;
        wait_clks(2);
        check_eq("irq_btn2", {31'd0, irq}, 32'd0);
        wait_clks(1);
        check_eq("irq_btn3", {31'd0, irq}, 32'd1);
        reg_wr(5'd5, 32'h2);
        check_eq("irq_btnclr", {31'd0, irq}, 32'd0);

        // Step interrupt
        reg_wr(5'd2, 32'h05);
        check_eq("irq_stp0", {31'd0, irq}, 32'd0);
        step(1'b1);
        check_eq("irq_stp1", {31'd0, irq}, 32'd1);
        reg_wr(5'd5, 32'h1);
        check_eq("irq_stpclr", {31'd0, irq}, 32'd0);

        // Asynchronous reset mid-count
        reg_wr(5'd2, 32'h07);
        step(1'b1);
        step(1'b1);
        drive_ab(next_ab(ab, 1'b1));
        check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_irq", {31'd0, irq}, 32'd0);
        expect_reg("arst_pos",  5'd0, '1, 32'd0);
        expect_reg("arst_ctrl", 5'd2, '1, 32'h1);
        drain();
        @(negedge clk);
        enc_a = 1'b0; enc_b = 1'b0; btn = 1'b0; ab = 2'b00;
        expect_reg("arst_status", 5'd1, '1, 32'h0);
        drain();
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(4);
        expect_reg("post_rst_pos", 5'd0, '1, 32'd0);
        expect_reg("post_rst_max", 5'd4, '1, 32'h0000_7FFF);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/enc_quad_counter.md
ENC_QUAD_COUNTER -- requirements
Module: enc_quad_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, signed position counter width (8..31).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have slot ports cs, read, write  input  1 each; addr input 5; wr_data input 32; rd_data output 32.
REQ-005 SHALL have port enc_a, enc_b  input  1 each  debounced quadrature phases from the encoder stage.
REQ-006 SHALL have port btn, sw  input  1 each  encoder push-button and slide switch levels.
REQ-007 SHALL have port irq  output  1  level interrupt request.

Function
REQ-008 SHALL pass enc_a, enc_b, btn, sw through 2-FF synchronizers; all logic uses synchronized values only.
REQ-009 SHALL hold prev_ab register; each cycle compare synced AB to prev_ab, then prev_ab <= synced AB.
REQ-010 SHALL decode x4: 00->01->11->10->00 = +1 (dir=1), reverse = -1 (dir=0), no change = 0.
REQ-011 SHALL treat double jumps (00<->11, 01<->10) as error: no count, set err sticky, increment 8-bit err_cnt saturating at 255.
REQ-012 SHALL have POS reflect an input edge within 3 clk cycles (2 sync + 1 update).
REQ-013 SHALL, when CTRL.enable=0, track prev_ab but neither count nor flag steps/errors.
REQ-014 SHALL bound counting by signed LIMIT_MIN/LIMIT_MAX: +1 at MAX -> MIN if CTRL.wrap else hold; -1 at MIN -> MAX if wrap else hold.
REQ-015 SHALL freeze counting (pos holds, step sticky still set) while LIMIT_MIN > LIMIT_MAX.
REQ-016 SHALL set step sticky on every counted or held +/-1 event; set btn sticky on synced btn rising edge.
REQ-017 SHALL, on btn rising edge with CTRL.clr_on_btn=1, load pos <= 0 (priority over same-cycle step).
REQ-018 SHALL give a CPU POS write priority over btn clear and step in the same cycle.
REQ-019 SHALL let a same-cycle new event win over a CLEAR write for that sticky bit.
REQ-020 SHALL drive irq = (CTRL.irq_step & step sticky) | (CTRL.irq_btn & btn sticky) | (CTRL.irq_err & err sticky).
REQ-021 SHALL accept writes when cs & write; register decode on addr:
 - 0 POS RW: read sign-extended to 32; write loads wr_data[CNT_W-1:0].
 - 1 STATUS RO: [0] dir, [1] sw, [2] btn, [3] step sticky, [4] btn sticky, [5] err sticky, [15:8] err_cnt.
 - 2 CTRL RW [5:0]: enable, wrap, irq_step, irq_btn, irq_err, clr_on_btn.
 - 3 LIMIT_MIN RW, 4 LIMIT_MAX RW: signed CNT_W, read sign-extended.
 - 5 CLEAR WO: bit0 step, bit1 btn, bit2 err sticky + err_cnt; reads 0.
REQ-022 SHALL drive rd_data combinationally from addr; unmapped addr and unused bits read 0; reads have no side effects.
REQ-023 SHALL ignore writes to RO/unmapped addresses.

Reset
REQ-024 SHALL on reset_n=0 set pos=0, dir=0, all stickies=0, err_cnt=0, CTRL=0x01 (enable only), LIMIT_MIN=-2^(CNT_W-1), LIMIT_MAX=2^(CNT_W-1)-1, syncs and prev_ab=00, irq=0.
REQ-025 SHALL return to reset values immediately on reset_n assertion mid-operation, independent of clk.

Verification
REQ-026 Four CW cycles (16 edges, 4 clk apart) from reset -> POS=16, dir=1, STATUS[3]=1; four CCW cycles -> POS=0, dir=0.
REQ-027 LIMIT_MAX=5, wrap=0, 8 CW steps -> POS=5; set wrap=1, LIMIT_MIN=-5, one CW step -> POS=-5.
REQ-028 AB 00->11 -> POS unchanged, err sticky=1, err_cnt=1; 300 jumps -> err_cnt=255; CLEAR=0x4 -> 0.
REQ-029 clr_on_btn=1, POS=7, btn rising with simultaneous step -> POS=0; same cycle CPU writes POS=9 -> POS=9.
REQ-030 irq_btn=1, btn press -> irq=1 within 3 clk; CLEAR=0x2 -> irq=0; reset_n low mid-count -> POS=0, CTRL=0x01 at once.
